imm_ext_arbiter: RTL and testbench
==================================

Name: imm_ext_arbiter

Overview:
- Shares one immediate-extension unit between two requesters: req0 is the decode stage and req1 is the branch-target precompute.
- Decodes the RV32I immediate format from the opcode, extends the immediate to XLEN, and returns it through a registered response channel tagged with the requester id.
- Arbitration is round-robin. Both channels use valid/ready handshakes.
- Sits between decode and the ALU/branch-target adders.

Parameters:
- XLEN, 32, width of the extended immediate and of rsp_imm.
- ERRCNT_W, 8, width of the saturating invalid-opcode counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 presents an instruction
- req0_ready  out  1  requester 0 instruction accepted this cycle
- req0_instr  in  32  requester 0 instruction word
- req1_valid  in  1  requester 1 presents an instruction
- req1_ready  out  1  requester 1 instruction accepted this cycle
- req1_instr  in  32  requester 1 instruction word
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_imm  out  XLEN  extended immediate
- rsp_fmt  out  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 7=none
- rsp_id  out  1  index of the requester that was served
- rsp_err  out  1  opcode carries no immediate
- err_count  out  ERRCNT_W  saturating count of accepted invalid opcodes

Behaviour:
- Reset (rst_n low at a clock edge):
  - rsp_valid=0, rsp_imm=0, rsp_fmt=7, rsp_id=0, rsp_err=0, err_count=0.
  - last_grant=1, so req0 wins the first contention.
  - Reset mid-transaction discards any held response; no handshake completes in that cycle.
- Output FSM, two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on rsp_ready with no new accept.
  - FULL → FULL on rsp_ready with a same-cycle accept (pass-through).
  - FULL holds when rsp_ready=0.
- can_accept = !rsp_valid || rsp_ready. This gives full throughput of one response per cycle.
- Grant logic:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the one not equal to last_grant.
  - reqX_ready = grant_X && can_accept. It is combinational and may depend on the valid inputs.
  - Requesters must not make valid depend on ready.
- On accept (valid && ready):
  - last_grant updates to the granted id.
  - The response register loads imm, fmt, id and err.
- Latency: one cycle from accept to rsp_valid=1.
- While rsp_valid=1 && rsp_ready=0, every response output is held stable.
- An unaccepted requester must hold its instr and valid. Fairness: no requester waits more than one response slot while the other is also valid.
- Format decode on instr[6:0]:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Any other opcode: fmt=7, imm=0, err=1.
- Immediate construction; the sign bit is always instr[31], replicated to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, no further extension.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- err_count increments on each accepted err=1 instruction and saturates at 2^ERRCNT_W-1.

Decomposition:
- Shared package holds:
  - opcode constants: OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL.
  - fmt enum: FMT_I..FMT_J, FMT_NONE=7.
  - state enum: EMPTY, FULL.
- Sub-module imm_gen: combinational, instr in → imm, fmt and err out. It replaces the fixed 12-bit extender and has no state.
- Arbiter, handshake and response register stay in the top level.

Test Plan:
- Reset, then req0_valid=1 with instr 0xFFF00093 (addi -1) and rsp_ready=1 → next cycle rsp_valid=1, rsp_imm=0xFFFFFFFF, fmt=0, id=0, err=0.
- Both valid: req0=0xFE112E23 (sw -4) and req1=0xFE000CE3 (beq -8), held for 2 cycles.
  - Required order: id=0 imm=0xFFFFFFFC fmt=1, then id=1 imm=0xFFFFFFF8 fmt=2.
  - Each requester's ready pulses exactly once.
- Backpressure: accept 0x123450B7 (lui), hold rsp_ready=0 for 3 cycles with req1 valid.
  - rsp_imm stays 0x12345000, fmt=3.
  - req1_ready stays 0.
  - After rsp_ready=1, req1 is accepted the same cycle.
- Streaming: req1 supplies back-to-back 0x0010006F (jal +2048) for 4 cycles with rsp_ready=1 → 4 responses, imm=0x00000800, fmt=4, no bubbles.
- Invalid opcode: 0x00000033 (add) accepted 3 times → rsp_err=1, imm=0, fmt=7, err_count=3. With ERRCNT_W=2, a 4th error leaves err_count=3.
- Reset asserted while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0 and err_count=0; req0 wins the next contention.

Source files
------------

// File: rtl/imm_ext_arbiter_pkg.sv
// Shared definitions for the immediate-extension arbiter: RV32I opcodes that
// carry an immediate, the response format encoding and the output FSM states.
package imm_ext_arbiter_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    // Response format code; FMT_NONE marks an opcode without an immediate.
    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } immFmt;

    // Occupancy of the single-entry response register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } outState;

endpackage

// File: rtl/imm_ext_arbiter_imm_gen.sv
// Purely combinational RV32I immediate decoder: picks the format from the
// opcode, assembles the immediate and sign-extends it from instr[31] to XLEN.
module imm_gen
    import imm_ext_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output immFmt           fmt,
    output logic            err
);

    // 32-bit immediate, already sign-extended from instr[31] where applicable
    logic [31:0] raw;

    // Opcode decode and per-format bit shuffling
    always_comb begin
        fmt = FMT_NONE;
        err = 1'b1;
        raw = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: begin
                fmt = FMT_I;
                err = 1'b0;
                raw = {{20{instr[31]}}, instr[31:20]};
            end
            STORE: begin
                fmt = FMT_S;
                err = 1'b0;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            BRANCH: begin
                fmt = FMT_B;
                err = 1'b0;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt = FMT_U;
                err = 1'b0;
                raw = {instr[31:12], 12'b0};
            end
            JAL: begin
                fmt = FMT_J;
                err = 1'b0;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                fmt = FMT_NONE;
                err = 1'b1;
                raw = '0;
            end
        endcase
    end

    // Widening beyond 32 bits keeps replicating the sign bit
    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate decoder between decode (req0) and
// branch-target precompute (req1), with a single registered response slot.
module imm_ext_arbiter
    import imm_ext_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [31:0]         req0_instr,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [31:0]         req1_instr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_imm,
    output logic [2:0]          rsp_fmt,
    output logic                rsp_id,
    output logic                rsp_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [1:0]          reqValid;
    logic [1:0]          grant;
    logic [1:0]          reqReady;
    logic                canAccept;
    logic                accept;
    logic                grantId;
    logic [31:0]         selInstr;
    logic [XLEN-1:0]     genImm;
    immFmt               genFmt;
    logic                genErr;

    outState             stateReg;
    logic                lastGrantReg;
    logic [XLEN-1:0]     rspImmReg;
    immFmt               rspFmtReg;
    logic                rspIdReg;
    logic                rspErrReg;
    logic [ERRCNT_W-1:0] errCountReg;

    assign reqValid  = {req1_valid, req0_valid};
    assign canAccept = (stateReg == EMPTY) || rsp_ready;

    // A requester wins when alone, or under contention when it was not served last
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi]    = reqValid[gi] &&
                                  (!reqValid[1-gi] || (lastGrantReg != 1'(gi)));
            assign reqReady[gi] = grant[gi] && canAccept;
        end
    endgenerate

    assign req0_ready = reqReady[0];
    assign req1_ready = reqReady[1];
    assign accept     = |(reqValid & reqReady);
    assign grantId    = grant[1];
    assign selInstr   = grantId ? req1_instr : req0_instr;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (selInstr),
        .imm   (genImm),
        .fmt   (genFmt),
        .err   (genErr)
    );

    // Output FSM and response register; a same-cycle pop and accept passes through
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg     <= EMPTY;
            lastGrantReg <= 1'b1;
            rspImmReg    <= '0;
            rspFmtReg    <= FMT_NONE;
            rspIdReg     <= 1'b0;
            rspErrReg    <= 1'b0;
            errCountReg  <= '0;
        end else begin
            if (accept) begin
                stateReg     <= FULL;
                lastGrantReg <= grantId;
                rspImmReg    <= genImm;
                rspFmtReg    <= genFmt;
                rspIdReg     <= grantId;
                rspErrReg    <= genErr;
                if (genErr && (errCountReg != '1)) begin
                    errCountReg <= errCountReg + ERRCNT_W'(1);
                end
            end else if (rsp_ready) begin
                stateReg <= EMPTY;
            end
        end
    end

    assign rsp_valid = (stateReg == FULL);
    assign rsp_imm   = rspImmReg;
    assign rsp_fmt   = rspFmtReg;
    assign rsp_id    = rspIdReg;
    assign rsp_err   = rspErrReg;
    assign err_count = errCountReg;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter; the error counter is narrowed to two bits
// so saturation is reachable with a handful of invalid opcodes.
module tb_imm_ext_arbiter;

    localparam int XLEN     = 32;
    localparam int ERRCNT_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req0_valid;
    logic                req0_ready;
    logic [31:0]         req0_instr;
    logic                req1_valid;
    logic                req1_ready;
    logic [31:0]         req1_instr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_imm;
    logic [2:0]          rsp_fmt;
    logic                rsp_id;
    logic                rsp_err;
    logic [ERRCNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    imm_ext_arbiter #(
        .XLEN     (XLEN),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_instr (req0_instr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_instr (req1_instr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_imm    (rsp_imm),
        .rsp_fmt    (rsp_fmt),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_instr = '0;   req1_instr = '0;
        rsp_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", rsp_valid); end
        checks++; if (rsp_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", rsp_imm); end
        checks++; if (rsp_fmt !== 3'd7) begin errors++; $display("FAIL reset_fmt got %0d exp 7", rsp_fmt); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %h exp 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %h exp 0", rsp_err); end
        checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
        $display("reset: valid=%0d fmt=%0d errcnt=%0d", rsp_valid, rsp_fmt, err_count);
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_instr = 32'hFFF00093; rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %h exp 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %h exp 1", rsp_valid); end
        checks++; if (rsp_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL single_imm got %h exp ffffffff", rsp_imm); end
        checks++; if (rsp_fmt !== 3'd0) begin errors++; $display("FAIL single_fmt got %0d exp 0", rsp_fmt); end
        checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err got %h/%h exp 0/0", rsp_id, rsp_err); end
        $display("single: id=%0d imm=%h fmt=%0d", rsp_id, rsp_imm, rsp_fmt);
        step();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %h exp 0", rsp_valid); end
    endtask

    task automatic test_contention();
        int r0 = 0;
        int r1 = 0;
        do_reset();
        req0_valid = 1'b1; req0_instr = 32'hFE112E23;
        req1_valid = 1'b1; req1_instr = 32'hFE000CE3;
        rsp_ready = 1'b1;
        #1;
        r0 += int'(req0_ready); r1 += int'(req1_ready);
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL cont_grant0 got %h%h exp 10", req0_ready, req1_ready); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_imm !== 32'hFFFFFFFC || rsp_fmt !== 3'd1) begin
            errors++; $display("FAIL cont_rsp0 got v=%h id=%h imm=%h fmt=%0d exp v=1 id=0 imm=fffffffc fmt=1", rsp_valid, rsp_id, rsp_imm, rsp_fmt); end
        $display("contention: id=%0d imm=%h fmt=%0d", rsp_id, rsp_imm, rsp_fmt);
        #1;
        r0 += int'(req0_ready); r1 += int'(req1_ready);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("FAIL cont_grant1 got %h%h exp 01", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_imm !== 32'hFFFFFFF8 || rsp_fmt !== 3'd2) begin
            errors++; $display("FAIL cont_rsp1 got v=%h id=%h imm=%h fmt=%0d exp v=1 id=1 imm=fffffff8 fmt=2", rsp_valid, rsp_id, rsp_imm, rsp_fmt); end
        $display("contention: id=%0d imm=%h fmt=%0d", rsp_id, rsp_imm, rsp_fmt);
        checks++; if (r0 != 1 || r1 != 1) begin errors++; $display("FAIL cont_pulses got %0d/%0d exp 1/1", r0, r1); end
        step();
    endtask

    task automatic test_backpressure();
        req0_valid = 1'b1; req0_instr = 32'h123450B7; rsp_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_instr = 32'h00100093;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %h exp 0", i, req1_ready); end
            checks++; if (rsp_valid !== 1'b1 || rsp_imm !== 32'h12345000 || rsp_fmt !== 3'd3) begin
                errors++; $display("FAIL bp_hold%0d got v=%h imm=%h fmt=%0d exp v=1 imm=12345000 fmt=3", i, rsp_valid, rsp_imm, rsp_fmt); end
            $display("backpressure %0d: imm=%h fmt=%0d r1rdy=%0d", i, rsp_imm, rsp_fmt, req1_ready);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %h exp 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_imm !== 32'h00000001 || rsp_fmt !== 3'd0) begin
            errors++; $display("FAIL bp_next got v=%h id=%h imm=%h fmt=%0d exp v=1 id=1 imm=00000001 fmt=0", rsp_valid, rsp_id, rsp_imm, rsp_fmt); end
        $display("backpressure release: id=%0d imm=%h", rsp_id, rsp_imm);
        step();
    endtask

    task automatic test_back_to_back();
        int got = 0;
        req1_valid = 1'b1; req1_instr = 32'h0010006F; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %h exp 1", i, req1_ready); end
            step();
            if (i == 3) req1_valid = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_imm !== 32'h00000800 || rsp_fmt !== 3'd4 || rsp_id !== 1'b1) begin
                errors++; $display("FAIL b2b_rsp%0d got v=%h imm=%h fmt=%0d id=%h exp v=1 imm=00000800 fmt=4 id=1", i, rsp_valid, rsp_imm, rsp_fmt, rsp_id); end
            else got++;
            $display("stream %0d: imm=%h fmt=%0d", i, rsp_imm, rsp_fmt);
        end
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got); end
        step();
    endtask

    task automatic test_invalid();
        logic [1:0] expCnt;
        req0_valid = 1'b1; req0_instr = 32'h00000033; rsp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 4) req0_valid = 1'b0;
            expCnt = (i > 3) ? 2'd3 : 2'(i);
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_imm !== 32'h0 || rsp_fmt !== 3'd7) begin
                errors++; $display("FAIL inv_rsp%0d got v=%h err=%h imm=%h fmt=%0d exp v=1 err=1 imm=0 fmt=7", i, rsp_valid, rsp_err, rsp_imm, rsp_fmt); end
            checks++; if (err_count !== expCnt) begin errors++; $display("FAIL inv_cnt%0d got %0d exp %0d", i, err_count, expCnt); end
            $display("invalid %0d: err=%0d fmt=%0d errcnt=%0d", i, rsp_err, rsp_fmt, err_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        // req0 served last, so without reset req1 would win the next contention
        req0_valid = 1'b1; req0_instr = 32'h00100093; rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %h exp 1", rsp_valid); end
        req1_valid = 1'b1; req1_instr = 32'h00000033;
        rst_n = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0 || err_count !== 2'd0) begin
            errors++; $display("FAIL mid_reset got v=%h errcnt=%0d exp v=0 errcnt=0", rsp_valid, err_count); end
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_instr = 32'hFFF00093;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_grant got %h%h exp 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_imm !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL mid_rsp got v=%h id=%h imm=%h exp v=1 id=0 imm=ffffffff", rsp_valid, rsp_id, rsp_imm); end
        $display("reset mid: id=%0d imm=%h", rsp_id, rsp_imm);
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
